// File: rtl/alu_pkg.sv
// Shared ALU definitions: optcodes, instruction field layout and decode helpers.
// Used by the operand-fetch stage, the ALU and their benches.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int NUM_OPS  = 10;
  localparam int OP_W     = 4;
  localparam int SHAMT_W  = 5;
  localparam int INSTR_W  = 16;

  localparam int OP_LSB    = 12;
  localparam int RD_LSB    = 9;
  localparam int RS1_LSB   = 6;
  localparam int RS2_LSB   = 3;
  localparam int SHAMT_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_ROR = 4'd8,
    OP_CMP = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [SHAMT_W-1:0] shamt;
  } instr_dec_t;

  // rs2 and shamt overlap in bits [4:3]; the op decides which one is meaningful.
  function automatic instr_dec_t decode_instr(input logic [INSTR_W-1:0] instr);
    instr_dec_t d;
    d.op    = instr[OP_LSB    +: OP_W];
    d.rd    = instr[RD_LSB    +: REG_AW];
    d.rs1   = instr[RS1_LSB   +: REG_AW];
    d.rs2   = instr[RS2_LSB   +: REG_AW];
    d.shamt = instr[SHAMT_LSB +: SHAMT_W];
    return d;
  endfunction

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR);
  endfunction

  function automatic logic writes_rd(input logic [OP_W-1:0] op, input logic [REG_AW-1:0] rd);
    return (rd != '0) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port; r0 is hardwired to zero.
module alu_regfile #(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int NUM_REGS = alu_pkg::NUM_REGS,
  parameter int AW       = alu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_operand_fetch.sv
// Decode / operand-fetch stage ahead of the ALU: register read with writeback
// bypass, pending-write scoreboard for hazard stalls, one-entry issue register.
module alu_operand_fetch #(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int NUM_REGS = alu_pkg::NUM_REGS,
  parameter int NUM_OPS  = alu_pkg::NUM_OPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_optcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shift,
  output logic [2:0]        alu_rd,
  output logic              alu_wb_en,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  import alu_pkg::*;

  instr_dec_t          dec;
  logic                op_illegal;
  logic                op_shift;
  logic                op_writes;
  logic                stall;
  logic                xfer;
  logic                issue;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_REGS-1:0] iss_set;
  logic [DATA_W-1:0]   rf_a;
  logic [DATA_W-1:0]   rf_b;
  logic [DATA_W-1:0]   opnd_a;
  logic [DATA_W-1:0]   opnd_b;

  alu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (3)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (dec.rs1),
    .rdata_a (rf_a),
    .raddr_b (dec.rs2),
    .rdata_b (rf_b)
  );

  assign dec        = decode_instr(in_instr);
  assign op_illegal = int'(dec.op) >= NUM_OPS;
  assign op_shift   = is_shift_op(dec.op);
  assign op_writes  = writes_rd(dec.op, dec.rd);

  // A writeback in this cycle resolves its hazard immediately (data is bypassed).
  always_comb begin
    wb_clr = '0;
    if (wb_en) begin
      wb_clr = NUM_REGS'(1) << wb_addr;
    end
    pend_eff = pending & ~wb_clr;
  end

  always_comb begin
    stall = 1'b0;
    if (!op_illegal) begin
      stall = pend_eff[dec.rs1]
            || (!op_shift && pend_eff[dec.rs2])
            || (op_writes && pend_eff[dec.rd]);
    end
  end

  assign in_ready = rst_n && !stall && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign issue    = xfer && !op_illegal;

  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (wb_en && (wb_addr == dec.rs1) && (dec.rs1 != '0)) begin
      opnd_a = wb_data;
    end
    if (wb_en && (wb_addr == dec.rs2) && (dec.rs2 != '0)) begin
      opnd_b = wb_data;
    end
  end

  // Set is applied after clear so an issue to rX wins over a same-cycle wb to rX.
  always_comb begin
    iss_set = '0;
    if (issue && op_writes) begin
      iss_set = NUM_REGS'(1) << dec.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      illegal <= 1'b0;
    end else begin
      pending <= (pending & ~wb_clr) | iss_set;
      illegal <= xfer && op_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_optcode <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_shift   <= '0;
      alu_rd      <= '0;
      alu_wb_en   <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      alu_optcode <= dec.op;
      alu_a       <= opnd_a;
      alu_b       <= op_shift ? '0 : opnd_b;
      alu_shift   <= op_shift ? dec.shamt : '0;
      alu_rd      <= dec.rd;
      alu_wb_en   <= op_writes;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
